vga_fb_scanout: RTL and testbench

Responder end of the pixel-plot interface used by our drawing FSMs. It accepts single-pixel writes (x, y, colour, plot) into a 320x240x3 frame buffer and scans the buffer out as 640x480@60 VGA, with each stored pixel doubled in both dimensions. It sits between the drawing engines and the board VGA DAC. It also provides a per-frame pulse so that drawers can synchronise to the frame.

---
 rtl/vga_fb_scanout.sv | 216 +++++++++++++++++++++
 tb/tb_vga_fb_scanout.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 320x240x3 frame buffer with a single-pixel write port.
// The buffer is scanned out as 640x480@60 VGA, and every stored pixel is
// doubled in both directions.
// Optional build macro FB_CLEAR_ON_RESET_EN: after reset, the buffer is
// cleared to BG_COLOUR one address per clock, and plot writes are held off
// until the clear completes.
`timescale 1ns/1ps
module vga_fb_scanout #(
    parameter int         FB_W      = 320,
    parameter int         FB_H      = 240,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         H_VIS     = 640,
    parameter int         H_FP      = 16,
    parameter int         H_SYNC    = 96,
    parameter int         H_BP      = 48,
    parameter int         V_VIS     = 480,
    parameter int         V_FP      = 10,
    parameter int         V_SYNC    = 2,
    parameter int         V_BP      = 33
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] colour,
    input  logic [8:0] x,
    input  logic [7:0] y,
    input  logic       plot,
    output logic       ready,
    output logic       frame_start,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK,
    output logic       VGA_SYNC,
    output logic       VGA_CLK
);
    localparam int          FB_DEPTH     = FB_W * FB_H;
    localparam int          AW           = $clog2(FB_DEPTH);
    localparam logic [16:0] FB_W_A       = 17'(FB_W);
    localparam logic [16:0] FB_H_A       = 17'(FB_H);
    localparam logic [16:0] FB_DEPTH_A   = 17'(FB_DEPTH);
    localparam logic [9:0]  H_FP_START   = 10'(H_VIS);
    localparam logic [9:0]  H_SYNC_START = 10'(H_VIS + H_FP);
    localparam logic [9:0]  H_BP_START   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  H_LAST       = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_VIS_L      = 10'(V_VIS);
    localparam logic [9:0]  V_SYNC_START = 10'(V_VIS + V_FP);
    localparam logic [9:0]  V_SYNC_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST       = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {S_ACTIVE, S_H_FRONT, S_H_SYNC, S_H_BACK} scan_t;

    scan_t       r_hstate;
    logic        r_pix_en;
    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic        r_frame_start;
    logic [2:0]  r_mem [0:FB_DEPTH-1];
    logic [2:0]  r_pix_p1;
    logic        r_vis_p1;
    logic        r_hs_p1;
    logic        r_vs_p1;
    logic [9:0]  r_r;
    logic [9:0]  r_g;
    logic [9:0]  r_b;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank;

    logic        w_vis;
    logic        w_hs_n;
    logic        w_vs_n;
    logic [16:0] w_rd_addr;
    logic        w_rd_ok;
    logic [16:0] w_x_a;
    logic [16:0] w_y_a;
    logic [16:0] w_plot_addr;
    logic        w_plot_ok;
    logic        w_ready;
    logic        w_clr_active;
    logic [16:0] w_clr_addr;
    logic        w_wr_en;
    logic [16:0] w_wr_addr;
    logic [2:0]  w_wr_data;

    // A lit colour bit drives the DAC to full scale, but only inside the visible region
    function automatic logic [9:0] dac_level(input logic bit_on, input logic vis);
        return (bit_on && vis) ? 10'h3FF : 10'h000;
    endfunction

    // Pixel-enable toggle, scan counters, horizontal phase FSM and frame pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pix_en      <= 1'b0;
            r_h           <= '0;
            r_v           <= '0;
            r_hstate      <= S_ACTIVE;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_en      <= ~r_pix_en;
            r_frame_start <= 1'b0;
            if (r_pix_en) begin
                if (r_h == H_LAST) begin
                    r_h      <= '0;
                    r_hstate <= S_ACTIVE;
                    if (r_v == V_LAST) begin
                        r_v           <= '0;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_v <= r_v + 10'd1;
                    end
                end else begin
                    r_h <= r_h + 10'd1;
                    case (r_hstate)
                        S_ACTIVE:  if (r_h == H_FP_START - 10'd1)   r_hstate <= S_H_FRONT;
                        S_H_FRONT: if (r_h == H_SYNC_START - 10'd1) r_hstate <= S_H_SYNC;
                        S_H_SYNC:  if (r_h == H_BP_START - 10'd1)   r_hstate <= S_H_BACK;
                        default:   r_hstate <= r_hstate;
                    endcase
                end
            end
        end
    end

    // Vertical phases are plain comparisons on the line count
    assign w_vis     = (r_hstate == S_ACTIVE) && (r_v < V_VIS_L);
    assign w_hs_n    = (r_hstate != S_H_SYNC);
    assign w_vs_n    = !((r_v >= V_SYNC_START) && (r_v < V_SYNC_END));
    assign w_rd_addr = {8'd0, r_v[9:1]} * FB_W_A + {8'd0, r_h[9:1]};
    assign w_rd_ok   = w_vis && (w_rd_addr < FB_DEPTH_A);

    // Out-of-range coordinates are dropped rather than aliased to another row
    assign w_x_a       = {8'd0, x};
    assign w_y_a       = {9'd0, y};
    assign w_plot_addr = w_y_a * FB_W_A + w_x_a;
    assign w_plot_ok   = plot && w_ready && (w_x_a < FB_W_A) && (w_y_a < FB_H_A)
                         && (w_plot_addr < FB_DEPTH_A);

`ifdef FB_CLEAR_ON_RESET_EN
    logic        r_ready;
    logic [16:0] r_clr_addr;

    // Clear sequencer: walks every address once after reset, holding off plot writes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ready    <= 1'b0;
            r_clr_addr <= '0;
        end else if (!r_ready) begin
            if (r_clr_addr == FB_DEPTH_A - 17'd1) r_ready <= 1'b1;
            r_clr_addr <= r_clr_addr + 17'd1;
        end
    end

    assign w_ready      = r_ready;
    assign w_clr_active = !r_ready && !reset;
    assign w_clr_addr   = r_clr_addr;
`else
    assign w_ready      = 1'b1;
    assign w_clr_active = 1'b0;
    assign w_clr_addr   = '0;
`endif

    assign w_wr_en   = w_clr_active || w_plot_ok;
    assign w_wr_addr = w_clr_active ? w_clr_addr : w_plot_addr;
    assign w_wr_data = w_clr_active ? BG_COLOUR : colour;

    // Frame-buffer write port and registered scan read (a same-address read sees the old data)
    always_ff @(posedge clock) begin
        if (w_wr_en) r_mem[w_wr_addr[AW-1:0]] <= w_wr_data;
        if (w_rd_ok) r_pix_p1 <= r_mem[w_rd_addr[AW-1:0]];
    end

    // Stage 1 timing flags, aligned with the registered memory read
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vis_p1 <= 1'b0;
            r_hs_p1  <= 1'b1;
            r_vs_p1  <= 1'b1;
        end else begin
            r_vis_p1 <= w_vis;
            r_hs_p1  <= w_hs_n;
            r_vs_p1  <= w_vs_n;
        end
    end

    // Stage 2 output registers: RGB blanked together with the sync/blank flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_blank <= 1'b0;
        end else begin
            r_r     <= dac_level(r_pix_p1[2], r_vis_p1);
            r_g     <= dac_level(r_pix_p1[1], r_vis_p1);
            r_b     <= dac_level(r_pix_p1[0], r_vis_p1);
            r_hs    <= r_hs_p1;
            r_vs    <= r_vs_p1;
            r_blank <= r_vis_p1;
        end
    end

    assign ready       = w_ready;
    assign frame_start = r_frame_start;
    assign VGA_R       = r_r;
    assign VGA_G       = r_g;
    assign VGA_B       = r_b;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK   = r_blank;
    assign VGA_SYNC    = 1'b0;
    assign VGA_CLK     = r_pix_en;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// Testbench for vga_fb_scanout. Horizontal timing is kept at full size.
// The vertical timing and frame height are scaled down (12 lines per frame,
// 3 stored rows), so that whole frames fit in a short run.
// Edge index k counts posedges after reset release (k=0 is the first edge
// with reset low). Pixel p = v*800+h is presented on the outputs after
// edges 2p+1 and 2p+2.
`timescale 1ns/1ps
module tb_vga_fb_scanout;
    localparam int FB_W   = 320;
    localparam int FB_H   = 3;
    localparam int V_VIS  = 6;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] colour;
    logic [8:0] x;
    logic [7:0] y;
    logic       plot;
    logic       ready;
    logic       frame_start;
    logic [9:0] VGA_R;
    logic [9:0] VGA_G;
    logic [9:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK;
    logic       VGA_SYNC;
    logic       VGA_CLK;

    vga_fb_scanout #(
        .FB_W(FB_W), .FB_H(FB_H),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clock(clock), .reset(reset), .colour(colour), .x(x), .y(y), .plot(plot),
        .ready(ready), .frame_start(frame_start),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
        .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK)
    );

    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   k;
    logic acc_en;
    logic prev_hs;
    int   hs_low = 0;
    int   hs_fall = 0;
    int   vs_low = 0;
    int   fs_cnt = 0;
    int   fs_k1 = 0;
    int   fs_k2 = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        k++;
        if (acc_en) begin
            if (k <= 19199) begin
                if (!VGA_HS) hs_low++;
                if (prev_hs && !VGA_HS) hs_fall++;
                if (!VGA_VS) vs_low++;
            end
            if (frame_start) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_k1 = k;
                else fs_k2 = k;
            end
            prev_hs = VGA_HS;
        end
    endtask

    task automatic adv_to(input int target);
        while (k < target) step();
    endtask

    task automatic do_plot(input int px, input int py, input logic [2:0] c);
        x      = 9'(px);
        y      = 8'(py);
        colour = c;
        plot   = 1'b1;
        @(posedge clock);
        #1;
        plot   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
        k = -1; acc_en = 1'b0; prev_hs = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check_val("rst_R", 32'(VGA_R), 32'h0);
        check_val("rst_G", 32'(VGA_G), 32'h0);
        check_val("rst_B", 32'(VGA_B), 32'h0);
        check_val("rst_HS", 32'(VGA_HS), 32'h1);
        check_val("rst_VS", 32'(VGA_VS), 32'h1);
        check_val("rst_BLANK", 32'(VGA_BLANK), 32'h0);
        check_val("rst_CLK", 32'(VGA_CLK), 32'h0);
        check_val("rst_fs", 32'(frame_start), 32'h0);
        check_val("rst_ready", 32'(ready), 32'h1);
        check_val("rst_SYNC", 32'(VGA_SYNC), 32'h0);

        // Zero the whole buffer, then place the test pixels
        reset = 1'b0;
        for (int a = 0; a < FB_W * FB_H; a++) do_plot(a % FB_W, a / FB_W, 3'b000);
        check_val("ready_run", 32'(ready), 32'h1);
        do_plot(100, 1, 3'b111);
        do_plot(0, 0, 3'b010);
        do_plot(319, 0, 3'b111);
        do_plot(320, 1, 3'b100);
        do_plot(10, FB_H, 3'b010);

        // One-clock reset, then timed scan checks
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0; k = -1; acc_en = 1'b1; prev_hs = 1'b1;

        adv_to(0);
        check_val("k0_BLANK", 32'(VGA_BLANK), 32'h0);
        check_val("k0_CLK", 32'(VGA_CLK), 32'h1);
        adv_to(1);
        check_val("px00_G", 32'(VGA_G), 32'h3FF);
        check_val("px00_R", 32'(VGA_R), 32'h0);
        check_val("px00_BLANK", 32'(VGA_BLANK), 32'h1);
        check_val("k1_CLK", 32'(VGA_CLK), 32'h0);
        adv_to(41);
        check_val("px10_0_G", 32'(VGA_G), 32'h0);
        check_val("px10_0_BLANK", 32'(VGA_BLANK), 32'h1);
        adv_to(1277);
        check_val("h638_R", 32'(VGA_R), 32'h3FF);
        adv_to(1279);
        check_val("h639_R", 32'(VGA_R), 32'h3FF);
        check_val("h639_BLANK", 32'(VGA_BLANK), 32'h1);
        adv_to(1280);
        check_val("h639_late_BLANK", 32'(VGA_BLANK), 32'h1);
        check_val("h639_late_B", 32'(VGA_B), 32'h3FF);
        adv_to(1281);
        check_val("h640_BLANK", 32'(VGA_BLANK), 32'h0);
        check_val("h640_R", 32'(VGA_R), 32'h0);
        adv_to(1312);
        check_val("hs_pre", 32'(VGA_HS), 32'h1);
        adv_to(1313);
        check_val("hs_first_low", 32'(VGA_HS), 32'h0);
        adv_to(1504);
        check_val("hs_last_low", 32'(VGA_HS), 32'h0);
        adv_to(1505);
        check_val("hs_post", 32'(VGA_HS), 32'h1);
        adv_to(3599);
        check_val("h199_v2_R", 32'(VGA_R), 32'h0);
        check_val("h199_v2_BLANK", 32'(VGA_BLANK), 32'h1);
        adv_to(3601);
        check_val("h200_v2_R", 32'(VGA_R), 32'h3FF);
        check_val("h200_v2_G", 32'(VGA_G), 32'h3FF);
        check_val("h200_v2_B", 32'(VGA_B), 32'h3FF);
        adv_to(3603);
        check_val("h201_v2_B", 32'(VGA_B), 32'h3FF);
        adv_to(3605);
        check_val("h202_v2_R", 32'(VGA_R), 32'h0);
        check_val("h202_v2_BLANK", 32'(VGA_BLANK), 32'h1);
        adv_to(5201);
        check_val("h200_v3_G", 32'(VGA_G), 32'h3FF);
        adv_to(6401);
        check_val("px0_2_R", 32'(VGA_R), 32'h0);
        check_val("px0_2_BLANK", 32'(VGA_BLANK), 32'h1);
        adv_to(9601);
        check_val("v6_BLANK", 32'(VGA_BLANK), 32'h0);
        adv_to(12800);
        check_val("vs_pre", 32'(VGA_VS), 32'h1);
        adv_to(12801);
        check_val("vs_first_low", 32'(VGA_VS), 32'h0);
        adv_to(16000);
        check_val("vs_last_low", 32'(VGA_VS), 32'h0);
        adv_to(16001);
        check_val("vs_post", 32'(VGA_VS), 32'h1);
        adv_to(19198);
        check_val("fs_before", 32'(frame_start), 32'h0);
        adv_to(19199);
        check_val("fs_pulse", 32'(frame_start), 32'h1);
        adv_to(19200);
        check_val("fs_after", 32'(frame_start), 32'h0);
        check_val("hs_low_clks", 32'(hs_low), 32'd2304);
        check_val("hs_pulses", 32'(hs_fall), 32'd12);
        check_val("vs_low_clks", 32'(vs_low), 32'd3200);
        adv_to(19201);
        check_val("f2_px00_G", 32'(VGA_G), 32'h3FF);
        adv_to(38400);
        check_val("fs_count", 32'(fs_cnt), 32'd2);
        check_val("fs_first_k", 32'(fs_k1), 32'd19199);
        check_val("fs_period", 32'(fs_k2 - fs_k1), 32'd19200);

        // Mid-frame reset while a lit visible pixel is on the outputs
        adv_to(42001);
        check_val("pre_rst_R", 32'(VGA_R), 32'h3FF);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_val("mid_rst_HS", 32'(VGA_HS), 32'h1);
        check_val("mid_rst_VS", 32'(VGA_VS), 32'h1);
        check_val("mid_rst_BLANK", 32'(VGA_BLANK), 32'h0);
        check_val("mid_rst_R", 32'(VGA_R), 32'h0);
        check_val("mid_rst_G", 32'(VGA_G), 32'h0);
        check_val("mid_rst_B", 32'(VGA_B), 32'h0);
        check_val("mid_rst_CLK", 32'(VGA_CLK), 32'h0);
        reset = 1'b0; k = -1; acc_en = 1'b0;
        adv_to(0);
        check_val("rel_k0_BLANK", 32'(VGA_BLANK), 32'h0);
        check_val("rel_k0_CLK", 32'(VGA_CLK), 32'h1);
        adv_to(1);
        check_val("rel_px00_G", 32'(VGA_G), 32'h3FF);
        check_val("rel_px00_R", 32'(VGA_R), 32'h0);
        adv_to(3601);
        check_val("rel_px100_R", 32'(VGA_R), 32'h3FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
